// File: rtl/multdiv_issue_if.sv
// Execute-stage / multiplier-divider handshake bundle for multdiv_issue.
// The master side is the pipeline plus the arithmetic units, and the slave side is the issue controller.
interface multdiv_issue_if;
    // Request from the execute stage
    logic        op_valid;
    logic        is_mult;
    logic        is_div;
    logic [4:0]  op_rd;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    // Operands and start pulses to the units
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    // Completion from the active unit
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    // Pipeline control and writeback
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal_op;

    modport master (
        output op_valid, is_mult, is_div, op_rd, op_a, op_b, flush,
        output md_result, md_exception, md_resultRDY,
        input  md_operandA, md_operandB, ctrl_MULT, ctrl_DIV,
        input  stall, wb_valid, wb_rd, wb_data, illegal_op
    );

    modport slave (
        input  op_valid, is_mult, is_div, op_rd, op_a, op_b, flush,
        input  md_result, md_exception, md_resultRDY,
        output md_operandA, md_operandB, ctrl_MULT, ctrl_DIV,
        output stall, wb_valid, wb_rd, wb_data, illegal_op
    );
endinterface

// File: rtl/multdiv_issue.sv
// Issue/retire controller for the multiplier and divider units.
// It latches one mult/div instruction, fires a one-cycle start pulse, and stalls the pipeline while the unit runs.
// When the unit reports ready, or the operation times out, it retires the instruction with a single register-file writeback.
module multdiv_issue #(
    parameter int unsigned TIMEOUT       = 40,
    parameter logic [4:0]  EXC_REG       = 5'd30,
    parameter logic [31:0] MULT_EXC_CODE = 32'd4,
    parameter logic [31:0] DIV_EXC_CODE  = 32'd5
) (
    input  logic           clock,
    input  logic           reset,
    multdiv_issue_if.slave bus
);
    localparam int unsigned            CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]       CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_is_div;
    logic [4:0]        r_rd;
    logic [31:0]       r_op_a;
    logic [31:0]       r_op_b;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ctrl_mult;
    logic              r_ctrl_div;
    logic              r_wb_valid;
    logic [4:0]        r_wb_rd;
    logic [31:0]       r_wb_data;

    logic              w_accept;
    logic              w_illegal;
    logic              w_timeout;
    logic              w_finish;
    logic              w_exc;

    // Writeback payload: the unit result, or the per-unit error code on an exception
    function automatic logic [31:0] wb_payload(input logic exc, input logic is_div,
                                               input logic [31:0] result);
        if (exc) begin
            wb_payload = is_div ? DIV_EXC_CODE : MULT_EXC_CODE;
        end else begin
            wb_payload = result;
        end
    endfunction

    // Decode the execute-stage request; only an idle controller can take a new op
    always_comb begin
        w_accept  = 1'b0;
        w_illegal = 1'b0;
        if ((r_state == S_IDLE) && !reset && bus.op_valid) begin
            w_accept  = (bus.is_mult ^ bus.is_div) & ~bus.flush;
            w_illegal = bus.is_mult & bus.is_div;
        end else begin
            w_accept  = 1'b0;
            w_illegal = 1'b0;
        end
    end

    // Retire decision while BUSY: a ready result beats a timeout on the same cycle
    always_comb begin
        w_timeout = (r_cnt == CNT_LAST);
        w_finish  = 1'b0;
        w_exc     = 1'b0;
        if (bus.md_resultRDY) begin
            w_finish = 1'b1;
            w_exc    = bus.md_exception;
        end else if (w_timeout) begin
            w_finish = 1'b1;
            w_exc    = 1'b1;
        end else begin
            w_finish = 1'b0;
            w_exc    = 1'b0;
        end
    end

    // Issue FSM with its latches, BUSY counter and registered unit/writeback outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_is_div    <= 1'b0;
            r_rd        <= 5'd0;
            r_op_a      <= 32'd0;
            r_op_b      <= 32'd0;
            r_cnt       <= '0;
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= 32'd0;
        end else begin
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            r_wb_valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_a      <= bus.op_a;
                        r_op_b      <= bus.op_b;
                        r_rd        <= bus.op_rd;
                        r_is_div    <= bus.is_div;
                        r_ctrl_mult <= bus.is_mult;
                        r_ctrl_div  <= bus.is_div;
                        r_state     <= S_START;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_START: begin
                    // The start pulse is already on the wire; a flush only cancels what follows
                    r_cnt   <= '0;
                    r_state <= bus.flush ? S_IDLE : S_BUSY;
                end
                S_BUSY: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end else begin
                            r_cnt <= r_cnt;
                        end
                        if (w_finish) begin
                            // r0 is hard-wired, so a clean result aimed at it is dropped
                            r_wb_valid <= w_exc | (r_rd != 5'd0);
                            r_wb_rd    <= w_exc ? EXC_REG : r_rd;
                            r_wb_data  <= wb_payload(w_exc, r_is_div, bus.md_result);
                            r_state    <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stall       = w_accept | (r_state == S_START) | (r_state == S_BUSY);
    assign bus.illegal_op  = w_illegal;
    assign bus.ctrl_MULT   = r_ctrl_mult;
    assign bus.ctrl_DIV    = r_ctrl_div;
    assign bus.md_operandA = r_op_a;
    assign bus.md_operandB = r_op_b;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_data     = r_wb_data;
endmodule

// File: doc/multdiv_issue.md
Name: multdiv_issue

Overview:
- Issue/retire controller between the execute stage and the multiplier/divider units.
- Accepts a mult or div instruction from execute and latches its operands and destination register.
- Fires a single-cycle start pulse to the unit and stalls the pipeline until the unit reports ready.
- Produces one register-file writeback; on an exception the writeback goes to the status register with an error code.

Parameters:
- TIMEOUT, 40, BUSY-cycle limit before a forced exception writeback.
- EXC_REG, 30, destination register number used on exception.
- MULT_EXC_CODE, 4, data written to EXC_REG on a mult exception.
- DIV_EXC_CODE, 5, data written to EXC_REG on a div exception.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- op_valid  in  1  execute stage holds a valid instruction.
- is_mult  in  1  instruction is mult.
- is_div  in  1  instruction is div.
- op_rd  in  5  destination register.
- op_a  in  32  operand A (dividend / multiplicand).
- op_b  in  32  operand B (divisor / multiplier).
- flush  in  1  pipeline flush; aborts any in-flight operation.
- md_operandA  out  32  latched A to the units.
- md_operandB  out  32  latched B to the units.
- ctrl_MULT  out  1  one-cycle mult start pulse.
- ctrl_DIV  out  1  one-cycle div start pulse.
- md_result  in  32  unit result (the active unit is selected by the latched op type).
- md_exception  in  1  unit exception flag.
- md_resultRDY  in  1  unit result valid.
- stall  out  1  freeze fetch/decode/execute.
- wb_valid  out  1  one-cycle register-file write enable.
- wb_rd  out  5  write address.
- wb_data  out  32  write data.
- illegal_op  out  1  one-cycle pulse when is_mult and is_div are both high.

Behaviour:
- Reset values:
  - state=IDLE; all latches 0; counter 0.
  - ctrl_MULT, ctrl_DIV, stall, wb_valid, illegal_op = 0.
  - wb_rd=0, wb_data=0, md_operandA/B=0.
- States: IDLE, START, BUSY, DONE (registered, 2-bit).
- IDLE:
  - Accept when op_valid & (is_mult ^ is_div) & ~flush.
  - On accept: latch op_a, op_b, op_rd and op type (1=div); go to START.
  - stall is combinationally high in the accept cycle: stall = accept | (state==START) | (state==BUSY).
  - op_valid & is_mult & is_div: no accept, illegal_op pulses for that cycle, state stays IDLE.
- START:
  - Exactly one of ctrl_MULT/ctrl_DIV is high, per the latched type. Both are registered outputs and high only in this state.
  - Counter cleared to 0. Next state BUSY.
- BUSY:
  - Counter increments every cycle, saturating at TIMEOUT.
  - md_resultRDY is sampled only in BUSY and ignored in all other states.
  - If md_resultRDY: capture md_result and md_exception, go to DONE.
  - Else if counter == TIMEOUT-1: force exception=1, go to DONE.
  - If resultRDY arrives on the same cycle as the timeout, resultRDY wins.
- DONE:
  - stall low; wb_valid high for exactly one cycle. Next state IDLE.
  - op_valid seen in DONE belongs to the retiring instruction and is not accepted; a new op is accepted from the following IDLE cycle.
  - No exception: wb_rd = latched rd, wb_data = captured result.
  - Exception: wb_rd = EXC_REG, wb_data = MULT_EXC_CODE or DIV_EXC_CODE per type.
  - Latched rd = 0 with no exception: wb_valid stays 0 (r0 is never written).
- Latency: accept at cycle N → start pulse N+1 → BUSY from N+2. With resultRDY first seen at N+2+k, wb_valid is at N+3+k.
- flush:
  - Any state except DONE → IDLE next cycle, no writeback, stall low from the next cycle.
  - A flush during START still lets the start pulse complete; the unit's later resultRDY is ignored because it is sampled only in BUSY.
- md_operandA/B hold their latched values from START through DONE, so the units see stable operands over the whole operation.
- reset mid-operation: immediate return to reset values; nothing is written back.

Test Plan:
- div 100/7 (op_rd=5): one ctrl_DIV pulse at N+1 → stall through BUSY; model resultRDY 33 cycles later with md_result=14 → wb_valid one cycle, wb_rd=5, wb_data=14, stall low.
- div 9/0, unit returns md_exception=1 → wb_rd=30, wb_data=5, no write to rd.
- mult with resultRDY never asserted → after 40 BUSY cycles wb_rd=30, wb_data=4; resultRDY on the timeout cycle → normal result written.
- is_mult=is_div=1 → illegal_op one cycle, no ctrl pulse, stall low; op_rd=0 div → no wb_valid.
- flush asserted in BUSY cycle 10, then resultRDY later → no wb_valid, state IDLE; back-to-back div then mult → second accepted only the cycle after DONE, ctrl_MULT pulse exactly once.
- reset asserted asynchronously mid-BUSY → all outputs 0 before the next clock edge; next op accepted normally after release.
